rll_enc_ctrl: RTL and testbench



---
 rtl/rll_enc_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rll_enc_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rll_enc_ctrl.sv
// Sequencer for a shared bit-serial RLL encoder: serialises words MSB-first, tracks encoder
// latency with a tag pipe and packs returned code pairs into output words. Macro: RLL_FLUSH_EN.
module rll_enc_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ENC_LAT    = 2,
  parameter int unsigned FLUSH_BITS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DATA_W-1:0]           s_data_i,
  input  logic                        s_valid_i,
  input  logic                        s_last_i,
  output logic                        s_ready_o,
  output logic                        enc_en_o,
  output logic                        enc_bit_o,
  input  logic [1:0]                  enc_code_i,
  output logic [2*DATA_W-1:0]         m_data_o,
  output logic [$clog2(DATA_W+1)-1:0] m_npairs_o,
  output logic                        m_last_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic                        busy_o
);
  localparam int unsigned BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned NPW = $clog2(DATA_W+1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W-1);
`ifdef RLL_FLUSH_EN
  localparam logic [BCW-1:0] FL_LAST = BCW'(FLUSH_BITS-1);
`endif

  if (ENC_LAT < 1 || ENC_LAT > 8 || FLUSH_BITS < 1 || FLUSH_BITS > DATA_W) begin : g_param_check
    $error("rll_enc_ctrl: ENC_LAT or FLUSH_BITS out of range");
  end

  // ST_LWAIT is the between-words wait of SHIFT: encoder frozen, slave port open.
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_LWAIT, ST_FLUSH, ST_DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_word, w_word_nxt;
  logic                r_last, w_last_nxt;
  logic [BCW-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [ENC_LAT-1:0]  r_tag_v, r_tag_l;
  logic                w_tag_v, w_tag_l;
  logic [2*DATA_W-1:0] r_coll, w_coll_base, w_coll_ins;
  logic [NPW-1:0]      r_cnt, w_cnt_base;
  logic                r_m_valid, r_m_last;
  logic                w_en, w_stall, w_take, w_accept;

  // Both ports: a transfer happens on a rising edge where valid and ready are both 1;
  // a held output word (valid=1, ready=0) keeps data, npairs and last unchanged.
  assign w_accept = r_m_valid && m_ready_i;
  assign w_stall  = r_m_valid && !m_ready_i && r_tag_v[ENC_LAT-1];
  assign w_take   = w_en && r_tag_v[ENC_LAT-1];

  always_comb begin
    w_state_nxt   = r_state;
    w_word_nxt    = r_word;
    w_last_nxt    = r_last;
    w_bit_cnt_nxt = r_bit_cnt;
    w_en          = 1'b0;
    w_tag_v       = 1'b0;
    w_tag_l       = 1'b0;
    enc_bit_o     = 1'b0;
    s_ready_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready_o = !rst_i;
        if (s_valid_i) begin
          w_word_nxt    = s_data_i;
          w_last_nxt    = s_last_i;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_en      = !w_stall;
        enc_bit_o = r_word[DATA_W-1];
        w_tag_v   = 1'b1;
`ifndef RLL_FLUSH_EN
        w_tag_l   = r_last && (r_bit_cnt == BIT_LAST);
`endif
        if (w_en) begin
          w_word_nxt    = r_word << 1;
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_nxt = '0;
            if (r_last) begin
`ifdef RLL_FLUSH_EN
              w_state_nxt = ST_FLUSH;
`else
              w_state_nxt = ST_DRAIN;
`endif
            end else begin
              s_ready_o = 1'b1;
              if (s_valid_i) begin
                w_word_nxt = s_data_i;
                w_last_nxt = s_last_i;
              end else begin
                w_state_nxt = ST_LWAIT;
              end
            end
          end
        end
      end
      ST_LWAIT: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          w_word_nxt    = s_data_i;
          w_last_nxt    = s_last_i;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
`ifdef RLL_FLUSH_EN
        w_en    = !w_stall;
        w_tag_v = 1'b1;
        w_tag_l = (r_bit_cnt == FL_LAST);
        if (w_en) begin
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          if (r_bit_cnt == FL_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = ST_DRAIN;
          end
        end
`else
        w_state_nxt = ST_DRAIN;
`endif
      end
      ST_DRAIN: begin
        w_en = !w_stall;
        if (!(|r_tag_v) && (!r_m_valid || m_ready_i)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A pair can only arrive while the held word is being accepted, so it starts a fresh word.
  always_comb begin
    w_cnt_base  = r_m_valid ? '0 : r_cnt;
    w_coll_base = r_m_valid ? '0 : r_coll;
    w_coll_ins  = w_coll_base;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (w_cnt_base == NPW'(i)) w_coll_ins[2*(int'(DATA_W)-1-i) +: 2] = enc_code_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_word    <= '0;
      r_last    <= 1'b0;
      r_bit_cnt <= '0;
      r_tag_v   <= '0;
      r_tag_l   <= '0;
      r_coll    <= '0;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_word    <= w_word_nxt;
      r_last    <= w_last_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      if (w_en) begin
        for (int i = int'(ENC_LAT) - 1; i > 0; i--) begin
          r_tag_v[i] <= r_tag_v[i-1];
          r_tag_l[i] <= r_tag_l[i-1];
        end
        r_tag_v[0] <= w_tag_v;
        r_tag_l[0] <= w_tag_l;
      end
      if (w_take) begin
        r_coll    <= w_coll_ins;
        r_cnt     <= w_cnt_base + NPW'(1);
        r_m_valid <= (w_cnt_base == NPW'(DATA_W-1)) || r_tag_l[ENC_LAT-1];
        r_m_last  <= r_tag_l[ENC_LAT-1];
      end else if (w_accept) begin
        r_coll    <= '0;
        r_cnt     <= '0;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  assign enc_en_o   = w_en;
  assign m_data_o   = r_coll;
  assign m_npairs_o = r_cnt;
  assign m_last_o   = r_m_last;
  assign m_valid_o  = r_m_valid;
  assign busy_o     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_rll_enc_ctrl.sv
// Bench for rll_enc_ctrl: stub {b,~b} encoder, frame-level reference model feeding an
// expected-word queue, and an independent output monitor. Honours RLL_FLUSH_EN.
module tb_rll_enc_ctrl;
  localparam int DATA_W     = 8;
  localparam int ENC_LAT    = 2;
  localparam int FLUSH_BITS = 4;
  localparam int NPW        = $clog2(DATA_W+1);
`ifdef RLL_FLUSH_EN
  localparam int FLUSH_N = FLUSH_BITS;
`else
  localparam int FLUSH_N = 0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [DATA_W-1:0]   s_data_i;
  logic                s_valid_i, s_last_i, s_ready_o;
  logic                enc_en_o, enc_bit_o;
  logic [1:0]          enc_code_i;
  logic [2*DATA_W-1:0] m_data_o;
  logic [NPW-1:0]      m_npairs_o;
  logic                m_last_o, m_valid_o, m_ready_i, busy_o;
  logic [ENC_LAT-1:0]  enc_pipe = '0;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;

  logic [2*DATA_W-1:0] exp_q[$];
  logic [NPW-1:0]      exp_np_q[$];
  logic                exp_last_q[$];
  logic [DATA_W-1:0]   frame_w[$];

  always #5 clk_i = ~clk_i;

  rll_enc_ctrl #(.DATA_W(DATA_W), .ENC_LAT(ENC_LAT), .FLUSH_BITS(FLUSH_BITS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .enc_en_o(enc_en_o), .enc_bit_o(enc_bit_o), .enc_code_i(enc_code_i),
    .m_data_o(m_data_o), .m_npairs_o(m_npairs_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .busy_o(busy_o)
  );

  // Stub encoder: returns {b,~b} for the bit issued ENC_LAT enabled cycles earlier.
  always @(posedge clk_i) begin
    if (enc_en_o) begin
      for (int i = ENC_LAT - 1; i > 0; i--) enc_pipe[i] <= enc_pipe[i-1];
      enc_pipe[0] <= enc_bit_o;
    end
  end
  assign enc_code_i = {enc_pipe[ENC_LAT-1], ~enc_pipe[ENC_LAT-1]};

  // Reference: frame bits (+ zero trailer) -> pairs -> DATA_W-pair words, last one partial.
  task automatic push_expected();
    logic bits[$];
    logic [2*DATA_W-1:0] w;
    int np, idx;
    foreach (frame_w[k]) for (int b = DATA_W - 1; b >= 0; b--) bits.push_back(frame_w[k][b]);
    repeat (FLUSH_N) bits.push_back(1'b0);
    idx = 0;
    while (idx < bits.size()) begin
      w = '0;
      np = 0;
      while (np < DATA_W && idx < bits.size()) begin
        w[2*DATA_W-1-2*np -: 2] = {bits[idx], ~bits[idx]};
        np++;
        idx++;
      end
      exp_q.push_back(w);
      exp_np_q.push_back(NPW'(np));
      exp_last_q.push_back(idx == bits.size());
    end
  endtask

  task automatic send_frame(input int gap_max);
    push_expected();
    foreach (frame_w[k]) begin
      int t;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        @(negedge clk_i);
        s_valid_i = 1'b0;
      end
      @(negedge clk_i);
      s_data_i  = frame_w[k];
      s_last_i  = (k == frame_w.size() - 1);
      s_valid_i = 1'b1;
      t = 0;
      forever begin
        #1;
        if (s_ready_o) begin
          @(posedge clk_i);
          break;
        end
        if (t == 300) begin
          checks++;
          errors++;
          $display("FAIL s_ready_timeout got=0 want=1");
          break;
        end
        t++;
        @(negedge clk_i);
      end
    end
    @(negedge clk_i);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (exp_q.size() != 0 || busy_o) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_pending busy=%0b want=0_pending busy=0", exp_q.size(), busy_o);
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({s_ready_o, enc_en_o, enc_bit_o, m_data_o, m_npairs_o, m_last_o, m_valid_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL %s got rdy=%0b en=%0b bit=%0b data=%h np=%0d last=%0b val=%0b busy=%0b want=all_0",
               name, s_ready_o, enc_en_o, enc_bit_o, m_data_o, m_npairs_o, m_last_o, m_valid_o, busy_o);
    end
  endtask

  // Back-to-back words must keep the encoder enabled for every pair of the frame.
  task automatic check_burst(input int n_pairs);
    int t = 0;
    do begin
      @(negedge clk_i);
      #2;
      t++;
    end while (!busy_o && t < 50);
    for (int c = 0; c < n_pairs; c++) begin
      checks++;
      if (enc_en_o !== 1'b1) begin
        errors++;
        $display("FAIL burst_en cycle=%0d got=%0b want=1", c, enc_en_o);
      end
      if (c < DATA_W) begin
        checks++;
        if (s_ready_o !== (c == DATA_W - 1)) begin
          errors++;
          $display("FAIL burst_ready cycle=%0d got=%0b want=%0b", c, s_ready_o, c == DATA_W - 1);
        end
      end
      @(negedge clk_i);
      #2;
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    if (rand_ready) m_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops on each accepted word, checks holds and the busy drop after a final word.
  initial begin
    logic [2*DATA_W-1:0] hold_d, ed;
    logic [NPW-1:0] hold_np, enp;
    logic hold_l, el;
    bit hold_pending = 0;
    bit busy_pending = 0;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        hold_pending = 0;
        busy_pending = 0;
      end else begin
        if (busy_pending) begin
          checks++;
          if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop got=%0b want=0", busy_o);
          end
          busy_pending = 0;
        end
        if (hold_pending) begin
          checks++;
          if ({m_valid_o, m_data_o, m_npairs_o, m_last_o} !== {1'b1, hold_d, hold_np, hold_l}) begin
            errors++;
            $display("FAIL hold got val=%0b data=%h np=%0d last=%0b want val=1 data=%h np=%0d last=%0b",
                     m_valid_o, m_data_o, m_npairs_o, m_last_o, hold_d, hold_np, hold_l);
          end
          hold_pending = 0;
        end
        if (m_valid_o === 1'b1) begin
          if (m_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_word got=%h want=none", m_data_o);
            end else begin
              ed  = exp_q.pop_front();
              enp = exp_np_q.pop_front();
              el  = exp_last_q.pop_front();
              if ({m_data_o, m_npairs_o, m_last_o} !== {ed, enp, el}) begin
                errors++;
                $display("FAIL out_word got data=%h np=%0d last=%0b want data=%h np=%0d last=%0b",
                         m_data_o, m_npairs_o, m_last_o, ed, enp, el);
              end
              if (el) busy_pending = 1;
            end
          end else begin
            hold_pending = 1;
            hold_d  = m_data_o;
            hold_np = m_npairs_o;
            hold_l  = m_last_o;
          end
        end
      end
    end
  end

  initial begin
    int n, t;
    rst_i = 1'b1;
    s_data_i = '0;
    s_valid_i = 1'b0;
    s_last_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #3;
    check_reset("reset_outs");
    @(negedge clk_i);
    rst_i = 1'b0;

    frame_w = {8'hA5};
    send_frame(0);
    wait_idle();

    frame_w = {8'hFF, 8'h00};
    fork
      send_frame(0);
      check_burst(2 * DATA_W + FLUSH_N);
    join
    wait_idle();

    // Backpressure: hold the first output word for ten cycles.
    @(negedge clk_i);
    m_ready_i = 1'b0;
    frame_w = {8'h3C};
    send_frame(0);
    t = 0;
    do begin
      @(negedge clk_i);
      #3;
      t++;
    end while (!m_valid_o && t < 100);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (!m_valid_o || exp_q.size() == 0 || m_data_o !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_data cycle=%0d got val=%0b data=%h want val=1 data=%h", i, m_valid_o, m_data_o,
                 (exp_q.size() != 0) ? exp_q[0] : '0);
      end
      if (i >= ENC_LAT && exp_last_q.size() != 0) begin
        checks++;
        if (enc_en_o !== exp_last_q[0]) begin
          errors++;
          $display("FAIL bp_en cycle=%0d got=%0b want=%0b", i, enc_en_o, exp_last_q[0]);
        end
      end
      @(negedge clk_i);
      #3;
    end
    @(negedge clk_i);
    m_ready_i = 1'b1;
    wait_idle();

    // Reset while bit 3 of a word is on enc_bit_o; the frame is discarded.
    frame_w = {8'h5A};
    send_frame(0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    exp_q.delete();
    exp_np_q.delete();
    exp_last_q.delete();
    @(negedge clk_i);
    #3;
    check_reset("midframe_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    frame_w = {8'h81};
    send_frame(0);
    wait_idle();

    // Random frames, random word gaps, random downstream backpressure.
    @(negedge clk_i);
    rand_ready = 1;
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 4);
      frame_w.delete();
      repeat (n) frame_w.push_back(DATA_W'($urandom));
      send_frame(2);
    end
    @(negedge clk_i);
    rand_ready = 0;
    m_ready_i = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
